// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I pipeline: hazard FSM state encoding,
// the hard-wired zero register index and the NOP used by flush consumers.
package rv32_pkg;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0]  X0  = 5'd0;
  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: advances on inc_i and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, branch flush,
// load-use bubble and fetch wait, plus saturating debug counters.
module pipeline_hazard_ctrl
  import rv32_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam logic [7:0] TO_MAX  = 8'(TIMEOUT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}
  localparam logic [5:0] CTRL_RUN = 6'b110101;

  hz_state_e  state_q, state_d;
  logic       pend_flush_q, pend_flush_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;

  logic       frozen, load_use, flush_apply;
  logic [5:0] ctrl_raw;

  assign frozen   = (state_q == ST_MEM_WAIT) || (dmem_req && !dmem_ready);
  assign load_use = ex_is_load && (ex_rd != X0) &&
                    ((id_use_rs && (id_rs == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    ctrl_raw      = CTRL_RUN;
    state_d       = state_q;
    pend_flush_d  = pend_flush_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    flush_apply   = 1'b0;
    if (frozen) begin
      ctrl_raw = 6'b000000;
      if (ex_branch_taken) pend_flush_d = 1'b1;
      if (state_q == ST_RUN) begin
        state_d = ST_MEM_WAIT;
      end else begin
        // The current MEM_WAIT cycle counts toward the timeout.
        if (wait_cnt_q == TO_LAST) mem_timeout_d = 1'b1;
        if (dmem_ready) state_d = ST_RUN;
        else            wait_cnt_d = (wait_cnt_q == TO_MAX) ? wait_cnt_q : wait_cnt_q + 8'd1;
      end
    end else if (ex_branch_taken || pend_flush_q) begin
      ctrl_raw     = 6'b111111;
      flush_apply  = 1'b1;
      pend_flush_d = 1'b0;
    end else if (load_use) begin
      ctrl_raw = 6'b000111;
    end else if (!imem_ready) begin
      ctrl_raw = 6'b011101;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      pend_flush_q  <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_flush_q  <= pend_flush_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // While reset is held the register controls show the RUN defaults regardless of inputs.
  assign {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en} =
         rst_n ? ctrl_raw : CTRL_RUN;
  assign mem_timeout = mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (!ctrl_raw[5]),
    .count_o(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (flush_apply),
    .count_o(flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl built with CNT_W=4 and TIMEOUT=4.
module tb_pipeline_hazard_ctrl;
  import rv32_pkg::*;

  localparam logic [5:0] V_RUN    = 6'b110101;
  localparam logic [5:0] V_FREEZE = 6'b000000;
  localparam logic [5:0] V_FLUSH  = 6'b111111;
  localparam logic [5:0] V_LDUSE  = 6'b000111;
  localparam logic [5:0] V_FETCH  = 6'b011101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rs2, ex_rd;
  logic       id_use_rs, id_use_rs2, ex_is_load, ex_branch_taken;
  logic       dmem_req, dmem_ready, imem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
  logic [3:0] stall_cnt, flush_cnt;
  logic       mem_timeout;
  logic [5:0] ctrl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs          (id_rs),
    .id_rs2         (id_rs2),
    .id_use_rs      (id_use_rs),
    .id_use_rs2     (id_use_rs2),
    .ex_rd          (ex_rd),
    .ex_is_load     (ex_is_load),
    .ex_branch_taken(ex_branch_taken),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .imem_ready     (imem_ready),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_en       (id_ex_en),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_en      (ex_mem_en),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .mem_timeout    (mem_timeout)
  );

  assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rs2 = 5'd0; id_use_rs = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_ctrl", 32'(ctrl), 32'(V_RUN));
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    chk("rst_tmo", 32'(mem_timeout), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("run_ctrl", 32'(ctrl), 32'(V_RUN));
    tick();

    // Load-use on rs1
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    #1 chk("lu_ctrl", 32'(ctrl), 32'(V_LDUSE));
    tick();
    chk("lu_stall", 32'(stall_cnt), 32'd1);
    idle();
    #1 chk("lu_after", 32'(ctrl), 32'(V_RUN));
    tick();

    // x0 destination and unused rs2 never stall
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #1 chk("x0_ctrl", 32'(ctrl), 32'(V_RUN));
    tick();
    ex_rd = 5'd7; id_rs = 5'd3; id_rs2 = 5'd7; id_use_rs2 = 1'b0;
    #1 chk("rs2_unused", 32'(ctrl), 32'(V_RUN));
    tick();
    chk("filt_stall", 32'(stall_cnt), 32'd1);
    id_use_rs2 = 1'b1;
    #1 chk("rs2_used", 32'(ctrl), 32'(V_LDUSE));
    tick();
    chk("rs2_stall", 32'(stall_cnt), 32'd2);

    // Branch squashes a simultaneous load-use
    ex_branch_taken = 1'b1;
    #1 chk("br_lu_ctrl", 32'(ctrl), 32'(V_FLUSH));
    tick();
    chk("br_flush", 32'(flush_cnt), 32'd1);
    chk("br_stall", 32'(stall_cnt), 32'd2);
    idle();

    // Zero-wait access
    dmem_req = 1'b1; dmem_ready = 1'b1;
    #1 chk("zw_ctrl", 32'(ctrl), 32'(V_RUN));
    tick();
    chk("zw_stall", 32'(stall_cnt), 32'd2);

    // Three-cycle memory wait with a branch in wait cycle 2
    for (int i = 0; i < 4; i++) begin
      dmem_req = 1'b1; dmem_ready = (i == 3); ex_branch_taken = (i == 2);
      #1 chk("mw_ctrl", 32'(ctrl), 32'(V_FREEZE));
      chk("mw_state", 32'(dut.state_q), (i == 0) ? 32'(ST_RUN) : 32'(ST_MEM_WAIT));
      tick();
    end
    idle();
    chk("mw_stall", 32'(stall_cnt), 32'd6);
    chk("mw_state_run", 32'(dut.state_q), 32'(ST_RUN));
    #1 chk("mw_pend_flush", 32'(ctrl), 32'(V_FLUSH));
    tick();
    chk("mw_flush_cnt", 32'(flush_cnt), 32'd2);
    #1 chk("mw_pend_clr", 32'(ctrl), 32'(V_RUN));
    tick();

    // Timeout, then reset mid-wait (branch pulse leaves a pending flush behind)
    for (int i = 0; i < 6; i++) begin
      dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = (i == 2);
      #1 chk("to_ctrl", 32'(ctrl), 32'(V_FREEZE));
      tick();
      chk("to_flag", 32'(mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
    end
    ex_branch_taken = 1'b0;
    chk("to_still_wait", 32'(dut.state_q), 32'(ST_MEM_WAIT));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(dut.state_q), 32'(ST_RUN));
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    chk("ar_flush", 32'(flush_cnt), 32'd0);
    chk("ar_tmo", 32'(mem_timeout), 32'd0);
    chk("ar_ctrl", 32'(ctrl), 32'(V_RUN));
    tick();
    idle();
    rst_n = 1'b1;
    #1 chk("ar_no_pend", 32'(ctrl), 32'(V_RUN));
    tick();

    // Fetch wait drives stall_cnt into saturation
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'b0;
      #1 chk("fw_ctrl", 32'(ctrl), 32'(V_FETCH));
      tick();
      chk("fw_stall", 32'(stall_cnt), (i >= 14) ? 32'd15 : 32'(i + 1));
    end
    idle();
    #1 chk("sat_run", 32'(ctrl), 32'(V_RUN));
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It drives the enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers. It detects load-use hazards, applies taken-branch/jump flushes, and freezes the pipeline during data-memory wait states via a req/ready handshake. It also keeps saturating performance counters and a sticky memory-timeout flag for debug.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt (saturating).
TIMEOUT, 255, max consecutive MEM_WAIT cycles before mem_timeout sets; 8-bit range, 1..255.

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
id_rs  in  5  rs1 index of instruction in ID.
id_rs2  in  5  rs2 index of instruction in ID.
id_use_rs  in  1  ID instruction reads rs1.
id_use_rs2  in  1  ID instruction reads rs2.
ex_rd  in  5  rd of instruction in EX.
ex_is_load  in  1  EX instruction is a load.
ex_branch_taken  in  1  EX resolved a taken branch or jump (PC redirect this cycle).
dmem_req  in  1  MEM stage issuing a load/store.
dmem_ready  in  1  data memory completes the access this cycle.
imem_ready  in  1  instruction fetch data valid this cycle.
pc_en  out  1  PC register update enable.
if_id_en  out  1  IF/ID register load enable.
if_id_flush  out  1  IF/ID loads a NOP (flush overrides enable).
id_ex_en  out  1  ID/EX load enable.
id_ex_flush  out  1  ID/EX loads a bubble.
ex_mem_en  out  1  EX/MEM load enable.
stall_cnt  out  CNT_W  cycles with pc_en=0 since reset.
flush_cnt  out  CNT_W  branch flush events applied since reset.
mem_timeout  out  1  sticky: MEM_WAIT exceeded TIMEOUT cycles.

Behaviour:
- FSM states: RUN, MEM_WAIT. Control outputs are Mealy (state plus current inputs). Counters and flags are registered.
- Reset (rst_n=0, async): state=RUN, pend_flush=0, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
- Outputs during reset follow the RUN defaults: pc_en=1, if_id_en=1, id_ex_en=1, ex_mem_en=1, flushes=0.
- Priority, highest first: memory freeze > branch flush > load-use > fetch wait.
- Memory freeze applies in RUN when dmem_req=1 and dmem_ready=0, and in every MEM_WAIT cycle.
  - Outputs: all four enables 0, both flushes 0.
  - RUN moves to MEM_WAIT on this condition.
  - MEM_WAIT returns to RUN in the cycle dmem_ready=1. That cycle is itself still frozen, so the pipeline advances on the following edge.
- A zero-wait access (dmem_req=1, dmem_ready=1 in RUN) causes no stall.
- Branch during freeze: ex_branch_taken=1 in a frozen cycle sets pend_flush. The flush is applied in the first non-frozen cycle, then pend_flush clears.
- Branch flush applies in a non-frozen cycle when ex_branch_taken or pend_flush is set.
  - Outputs: if_id_flush=1, id_ex_flush=1, all enables 1.
  - flush_cnt increments once.
  - Any load-use condition in the same cycle is ignored, because the ID instruction is squashed.
- Load-use applies when not frozen, no flush, ex_is_load=1, ex_rd!=0, and either (id_use_rs and id_rs==ex_rd) or (id_use_rs2 and id_rs2==ex_rd).
  - Outputs: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1.
  - The bubble lasts exactly one cycle, because the load then leaves EX.
- Fetch wait applies when none of the above hold and imem_ready=0.
  - Outputs: pc_en=0, if_id_flush=1 (bubble enters ID), other enables 1.
- stall_cnt increments in every cycle with pc_en=0. flush_cnt increments per applied flush. Both saturate at all-ones and never wrap.
- wait_cnt counts consecutive MEM_WAIT cycles and clears on the return to RUN.
  - When wait_cnt reaches TIMEOUT, mem_timeout sets and stays set until reset.
  - The FSM keeps waiting; there is no abort.
- Asserting reset in the middle of MEM_WAIT returns the FSM to RUN immediately and discards pend_flush.

Decomposition:
- Shared package rv32_pkg: state encoding (ST_RUN, ST_MEM_WAIT), the X0 register-index constant, and the NOP instruction constant used by flush consumers.
- One natural sub-module, sat_counter (parameter W; inc in, count out; async active-low reset), instantiated twice for stall_cnt and flush_cnt.
- Hazard compare logic stays inline.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs=5, id_use_rs=1. Expect one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt 0→1, and the next cycle back to all enables 1.
- X0 and unused-operand filter: ex_rd=0 with id_rs=0, then id_rs2=7 with id_use_rs2=0 and ex_rd=7. Expect no stall in either case.
- Branch plus load-use in the same cycle: expect if_id_flush=1, id_ex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait of 3 cycles: dmem_req=1, dmem_ready low for 3 cycles then high.
  - Expect 4 frozen cycles, state MEM_WAIT for 3 cycles, stall_cnt=4.
  - With ex_branch_taken pulsed in wait cycle 2, expect the flush in the first cycle after the freeze.
- Timeout with TIMEOUT=4: hold dmem_ready=0 for 6 cycles. Expect mem_timeout=1 after the 4th MEM_WAIT cycle. Then assert rst_n=0 mid-wait and expect state RUN and all counters and flags 0 asynchronously.
- Saturation with CNT_W=4: hold imem_ready=0 for 20 cycles. Expect stall_cnt=15 held, if_id_flush=1 each cycle.
